// File: rtl/multiplier_4x4_seq_pkg.sv
// Shared types and constants for the 4x4 shift-and-add multiplier.
// Used by the top (multiplier_4x4_seq) and its datapath adder.
package multiplier_4x4_seq_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int CNT_W  = 2;

  // Count value of the final add/shift iteration.
  localparam logic [CNT_W-1:0] ITER_LAST = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Partial-product register pair: hi is the running sum, q the multiplier bits.
  typedef struct packed {
    logic [OP_W-1:0] hi;
    logic [OP_W-1:0] q;
  } shreg_t;

  // Right-shift {sum, q} by one: sum[0] enters the top of q, q[0] drops out.
  function automatic shreg_t shift_step(input logic [OP_W:0] sum,
                                        input logic [OP_W-1:0] q);
    shreg_t r;
    r.hi = sum[OP_W:1];
    r.q  = {sum[0], q[OP_W-1:1]};
    return r;
  endfunction

endpackage

// File: rtl/multiplier_4x4_seq_adder.sv
// 4+4 ripple-carry adder with carry-in and a 5-bit result (adder_4_with_4).
// Used as the iteration datapath adder of multiplier_4x4_seq.
module adder_4_with_4
  import multiplier_4x4_seq_pkg::*;
(
  input  logic [OP_W-1:0] in1,
  input  logic [OP_W-1:0] in2,
  input  logic            carryin,
  output logic [OP_W:0]   sum
);

  logic [OP_W:0]   carry;
  logic [OP_W-1:0] sum_bits;

  always_comb begin
    carry    = '0;
    sum_bits = '0;
    carry[0] = carryin;
    for (int i = 0; i < OP_W; i++) begin
      sum_bits[i]  = in1[i] ^ in2[i] ^ carry[i];
      carry[i+1]   = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
    end
  end

  assign sum = {carry[OP_W], sum_bits};

endmodule

// File: rtl/multiplier_4x4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier (IDLE -> RUN x4 -> DONE).
// Define MULT_ACCUM_EN for multiply-accumulate mode with the acc_clr port.
module multiplier_4x4_seq
  import multiplier_4x4_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
`ifdef MULT_ACCUM_EN
  input  logic              acc_clr,
`endif
  output logic [PROD_W-1:0] product,
  output logic              done,
  output logic              busy
);

  // Handshake: start is a request sampled only while IDLE; a/b (and acc_clr)
  // are captured on that edge. done pulses one cycle with product valid from
  // that cycle onward; busy covers RUN and DONE, during which start is ignored.

  state_e              state_q, state_d;
  logic [OP_W-1:0]     m_q, m_d;
  logic [OP_W-1:0]     q_q, q_d;
  logic [OP_W-1:0]     hi_q, hi_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
`ifdef MULT_ACCUM_EN
  logic                acc_clr_q, acc_clr_d;
`endif

  logic [OP_W-1:0]     add_in2;
  logic [OP_W:0]       add_sum;
  shreg_t              step;
  logic [PROD_W-1:0]   step_prod;

  assign add_in2 = q_q[0] ? m_q : '0;

  adder_4_with_4 u_adder (
    .in1     (hi_q),
    .in2     (add_in2),
    .carryin (1'b0),
    .sum     (add_sum)
  );

  assign step      = shift_step(add_sum, q_q);
  assign step_prod = {step.hi, step.q};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    hi_d      = hi_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef MULT_ACCUM_EN
    acc_clr_d = acc_clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          m_d       = a;
          q_d       = b;
          hi_d      = '0;
          count_d   = '0;
`ifdef MULT_ACCUM_EN
          acc_clr_d = acc_clr;
`endif
        end
      end
      RUN: begin
        hi_d    = step.hi;
        q_d     = step.q;
        count_d = count_q + 2'd1;
        if (count_q == ITER_LAST) begin
          state_d = DONE;
`ifdef MULT_ACCUM_EN
          // Accumulation wraps modulo 256 without any flag.
          product_d = (acc_clr_q ? '0 : product_q) + step_prod;
`else
          product_d = step_prod;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered from the next state so they align with it.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      hi_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MULT_ACCUM_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      hi_q      <= hi_d;
      count_q   <= count_d;
      product_q <= product_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef MULT_ACCUM_EN
      acc_clr_q <= acc_clr_d;
`endif
    end
  end

  assign product = product_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_multiplier_4x4_seq.sv
// Self-checking bench for multiplier_4x4_seq (both default and MULT_ACCUM_EN builds).
module tb_multiplier_4x4_seq;

`ifdef MULT_ACCUM_EN
  localparam bit ACCUM = 1'b1;
`else
  localparam bit ACCUM = 1'b0;
`endif

  // Expected done/busy after edges E0..E8 of one operation (bit i = after Ei).
  localparam logic [8:0] EXP_DONE_V = 9'b0_0001_0000;
  localparam logic [8:0] EXP_BUSY_V = 9'b0_0001_1111;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a, b;
`ifdef MULT_ACCUM_EN
  logic       acc_clr;
`endif
  logic [7:0] product;
  logic       done, busy;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] model_acc = 8'h00;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  multiplier_4x4_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef MULT_ACCUM_EN
    .acc_clr (acc_clr),
`endif
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  // ---------------- reference model ----------------
  // Product register after one completed operation: a*b, optionally accumulated mod 256.
  function automatic logic [7:0] model_op(input logic [3:0] ia, input logic [3:0] ib,
                                          input logic clr);
    int full;
    if (!ACCUM || clr) model_acc = 8'h00;
    full      = int'(model_acc) + int'(ia) * int'(ib);
    model_acc = 8'(full % 256);
    return model_acc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input logic iclr,
                       output logic [8:0] done_v, output logic [8:0] busy_v,
                       output logic [7:0] p_done, output logic [7:0] p_pre);
    @(negedge clk);
    a = ia;
    b = ib;
`ifdef MULT_ACCUM_EN
    acc_clr = iclr;
`else
    if (iclr) start = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
`ifdef MULT_ACCUM_EN
    acc_clr = 1'($urandom);
`endif
    done_v = '0;
    busy_v = '0;
    p_done = '0;
    p_pre  = '0;
    done_v[0] = done;
    busy_v[0] = busy;
    for (int i = 1; i < 9; i++) begin
      @(posedge clk); #1;
      done_v[i] = done;
      busy_v[i] = busy;
      if (i == 3) p_pre  = product;
      if (i == 4) p_done = product;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_acc = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = 4'h0;
    b = 4'h0;
`ifdef MULT_ACCUM_EN
    acc_clr = 1'b0;
`endif
    #2;
    n_cmp++;
    if ({product, done, busy} !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_init: got product=%h done=%b busy=%b, required 00/0/0", product, done, busy);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_acc = 8'h00;
  endtask

  task automatic test_max();
    logic [8:0] dv, bv;
    logic [7:0] pd, pp, exp_p, prev;
    prev  = model_acc;
    exp_p = model_op(4'hF, 4'hF, 1'b1);
    do_op(4'hF, 4'hF, 1'b1, dv, bv, pd, pp);
    n_cmp++;
    if (dv !== EXP_DONE_V) begin
      n_fail++;
      $display("FAIL max_done_timing: got %b, required %b", dv, EXP_DONE_V);
    end
    n_cmp++;
    if (bv !== EXP_BUSY_V) begin
      n_fail++;
      $display("FAIL max_busy_timing: got %b, required %b", bv, EXP_BUSY_V);
    end
    n_cmp++;
    if (pd !== exp_p || exp_p !== 8'hE1) begin
      n_fail++;
      $display("FAIL max_product: got %h, required %h", pd, exp_p);
    end
    n_cmp++;
    if (pp !== prev) begin
      n_fail++;
      $display("FAIL max_product_hold: got %h before completion, required %h", pp, prev);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a = 4'hA;
    b = 4'h7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({product, done, busy} !== 10'h000) begin
      n_fail++;
      $display("FAIL async_reset: got product=%h done=%b busy=%b, required 00/0/0", product, done, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    model_acc = 8'h00;
  endtask

  task automatic test_zero_edges();
    logic [3:0] ta[3];
    logic [3:0] tb[3];
    logic [8:0] dv, bv;
    logic [7:0] pd, pp, exp_p;
    ta = '{4'h9, 4'h0, 4'h1};
    tb = '{4'h0, 4'h7, 4'h8};
    for (int i = 0; i < 3; i++) begin
      exp_p = model_op(ta[i], tb[i], 1'b1);
      do_op(ta[i], tb[i], 1'b1, dv, bv, pd, pp);
      n_cmp++;
      if (pd !== exp_p) begin
        n_fail++;
        $display("FAIL zero_edge_product[%0d]: got %h, required %h", i, pd, exp_p);
      end
      n_cmp++;
      if (dv !== EXP_DONE_V) begin
        n_fail++;
        $display("FAIL zero_edge_done[%0d]: got %b, required %b", i, dv, EXP_DONE_V);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int         ndone;
    int         done_edge;
    logic [7:0] p, exp_p;
    exp_p = model_op(4'h3, 4'h5, 1'b1);
    @(negedge clk);
    a = 4'h3;
    b = 4'h5;
`ifdef MULT_ACCUM_EN
    acc_clr = 1'b1;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    a = 4'h2;
    b = 4'h2;
    ndone = 0;
    done_edge = 0;
    p = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 5) start = 1'b0;
      if (done) begin
        ndone++;
        if (done_edge == 0) begin
          done_edge = i;
          p = product;
        end
      end
    end
    n_cmp++;
    if (ndone != 1 || done_edge != 4) begin
      n_fail++;
      $display("FAIL ignore_busy_done: got %0d pulses first at E%0d, required 1 at E4", ndone, done_edge);
    end
    n_cmp++;
    if (p !== exp_p || product !== exp_p) begin
      n_fail++;
      $display("FAIL ignore_busy_product: got %h/%h, required %h", p, product, exp_p);
    end
  endtask

  task automatic test_reset_abort();
    int         ndone;
    logic [8:0] dv, bv;
    logic [7:0] pd, pp, exp_p;
    @(negedge clk);
    a = 4'hD;
    b = 4'hB;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_acc = 8'h00;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone != 0 || product !== 8'h00 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got %0d done, product=%h busy=%b, required 0/00/0", ndone, product, busy);
    end
    exp_p = model_op(4'h6, 4'h7, 1'b0);
    do_op(4'h6, 4'h7, 1'b0, dv, bv, pd, pp);
    n_cmp++;
    if (pd !== exp_p || exp_p !== 8'h2A || dv !== EXP_DONE_V) begin
      n_fail++;
      $display("FAIL after_abort: got %h done_v=%b, required %h done_v=%b", pd, dv, exp_p, EXP_DONE_V);
    end
  endtask

  task automatic test_random();
    logic [3:0] ra, rb;
    logic       rc;
    logic [8:0] dv, bv;
    logic [7:0] pd, pp, exp_p, prev;
    for (int i = 0; i < 20; i++) begin
      ra    = 4'($urandom_range(0, 15));
      rb    = 4'($urandom_range(0, 15));
      rc    = ACCUM ? 1'($urandom_range(0, 1)) : 1'b1;
      prev  = model_acc;
      exp_p = model_op(ra, rb, rc);
      do_op(ra, rb, rc, dv, bv, pd, pp);
      n_cmp++;
      if (pd !== exp_p || pp !== prev) begin
        n_fail++;
        $display("FAIL random[%0d] %h*%h clr=%b: got %h (pre %h), required %h (pre %h)",
                 i, ra, rb, rc, pd, pp, exp_p, prev);
      end
      n_cmp++;
      if (dv !== EXP_DONE_V || bv !== EXP_BUSY_V) begin
        n_fail++;
        $display("FAIL random_timing[%0d]: got done %b busy %b, required %b %b",
                 i, dv, bv, EXP_DONE_V, EXP_BUSY_V);
      end
    end
  endtask

`ifdef MULT_ACCUM_EN
  task automatic test_accum();
    logic [3:0] ta[3];
    logic [3:0] tb[3];
    logic       tc[3];
    logic [7:0] req[3];
    logic [8:0] dv, bv;
    logic [7:0] pd, pp, exp_p;
    ta  = '{4'hF, 4'hF, 4'h2};
    tb  = '{4'hF, 4'hF, 4'h3};
    tc  = '{1'b0, 1'b0, 1'b1};
    req = '{8'hE1, 8'hC2, 8'h06};
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      exp_p = model_op(ta[i], tb[i], tc[i]);
      do_op(ta[i], tb[i], tc[i], dv, bv, pd, pp);
      n_cmp++;
      if (pd !== exp_p || exp_p !== req[i]) begin
        n_fail++;
        $display("FAIL accum[%0d]: got %h, required %h", i, pd, req[i]);
      end
    end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_max();
    test_async_reset();
    test_zero_edges();
    test_ignore_busy();
    test_reset_abort();
    test_random();
`ifdef MULT_ACCUM_EN
    test_accum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
